// File: rtl/imem_loader_pkg.sv
// Purpose: shared state encodings and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_LEN_HI = 3'd1,
    LDR_LEN_LO = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_CSUM   = 3'd4,
    LDR_DONE   = 3'd5,
    LDR_ERROR  = 3'd6
  } ldr_state_t;

  localparam int          LDR_DEPTH_DEFAULT = 1024;
  // PC that word index 0 of the instruction memory corresponds to.
  localparam logic [31:0] IM_BASE_PC        = 32'h0000_3000;

  // True in the states where a frame is in progress and bytes are taken.
  function automatic logic ldr_accepting(input ldr_state_t s);
    return (s == LDR_LEN_HI) || (s == LDR_LEN_LO) ||
           (s == LDR_DATA)   || (s == LDR_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_word_pack.sv
// Purpose: packs accepted bytes big-endian into 32-bit words (first byte -> bits 31:24).
// Latency: word/word_valid are combinational with the 4th byte; state updates on clk.
// Backpressure: none; only advances on in_fire.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        restart byte grouping at a frame boundary
//   in_fire      in_byte is being accepted this cycle
//   in_byte      accepted byte
//   word         assembled word (valid when word_valid is high)
//   word_valid   this cycle's byte completes a word
module ldr_word_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_fire,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  // Only the three earlier bytes of a group need storing; the fourth is
  // taken straight from the input on the completing cycle.
  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr  <= 24'd0;
      cnt <= 2'd0;
    end else if (in_fire) begin
      sr  <= {sr[15:0], in_byte};
      cnt <= cnt + 2'd1;
    end
  end

  assign word       = {sr, in_byte};
  assign word_valid = in_fire && (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Purpose: boot-time loader: framed byte stream -> sequential IM word writes, checksum check, CPU reset release.
// Latency: IM write registered on the edge accepting a word's 4th byte; done/error on the CSUM-accepting edge.
// Backpressure: in_ready only while a frame is in progress; bytes offered otherwise are simply not consumed.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   start          one-cycle request to begin a frame (ignored while busy)
//   in_valid/in_ready/in_data   byte stream, accepted when valid & ready
//   im_we/im_addr/im_wdata      IM write port, one strobe per word
//   words_loaded   words written in the current frame
//   busy/done/error  frame in progress / last frame good / last frame rejected
//   cpu_reset      holds the CPU in reset until a frame loads cleanly
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = LDR_DEPTH_DEFAULT,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_reset
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  ldr_state_t        state, state_nxt;
  logic              in_ready_nxt, busy_nxt, done_nxt, error_nxt, cpu_reset_nxt;
  logic              im_we_nxt;
  logic [ADDR_W-1:0] im_addr_nxt;
  logic [31:0]       im_wdata_nxt;
  logic [ADDR_W:0]   words_nxt;
  logic [ADDR_W-1:0] word_idx, word_idx_nxt;
  logic [7:0]        len_hi, len_hi_nxt;
  logic [15:0]       len_q, len_nxt;
  logic [7:0]        xsum, xsum_nxt;
  logic [15:0]       len_rx;

  logic              fire;
  logic              pack_fire, pack_clear;
  logic [31:0]       pack_word;
  logic              pack_word_valid;

  // in_ready is a register, so fire cannot depend on anything combinational.
  assign fire       = in_valid && in_ready;
  assign pack_fire  = fire && (state == LDR_DATA);
  assign pack_clear = start && !ldr_accepting(state);
  assign len_rx     = {len_hi, in_data};

  ldr_word_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (pack_clear),
    .in_fire    (pack_fire),
    .in_byte    (in_data),
    .word       (pack_word),
    .word_valid (pack_word_valid)
  );

  always_comb begin
    state_nxt     = state;
    im_we_nxt     = 1'b0;
    im_addr_nxt   = im_addr;
    im_wdata_nxt  = im_wdata;
    words_nxt     = words_loaded;
    done_nxt      = done;
    error_nxt     = error;
    cpu_reset_nxt = cpu_reset;
    word_idx_nxt  = word_idx;
    len_hi_nxt    = len_hi;
    len_nxt       = len_q;
    xsum_nxt      = xsum;

    case (state)
      LDR_IDLE, LDR_DONE, LDR_ERROR: begin
        if (start) begin
          state_nxt     = LDR_LEN_HI;
          word_idx_nxt  = '0;
          words_nxt     = '0;
          xsum_nxt      = 8'd0;
          done_nxt      = 1'b0;
          error_nxt     = 1'b0;
          cpu_reset_nxt = 1'b1;
        end
      end

      LDR_LEN_HI: begin
        if (fire) begin
          len_hi_nxt = in_data;
          xsum_nxt   = xsum ^ in_data;
          state_nxt  = LDR_LEN_LO;
        end
      end

      LDR_LEN_LO: begin
        if (fire) begin
          len_nxt  = len_rx;
          xsum_nxt = xsum ^ in_data;
          // Oversize frames are rejected before any write reaches the IM.
          if (len_rx > DEPTH16) begin
            state_nxt = LDR_ERROR;
            error_nxt = 1'b1;
          end else if (len_rx == 16'd0) begin
            state_nxt = LDR_CSUM;
          end else begin
            state_nxt = LDR_DATA;
          end
        end
      end

      LDR_DATA: begin
        if (fire) begin
          xsum_nxt = xsum ^ in_data;
          if (pack_word_valid) begin
            im_we_nxt    = 1'b1;
            im_addr_nxt  = word_idx;
            im_wdata_nxt = pack_word;
            word_idx_nxt = word_idx + 1'b1;
            words_nxt    = words_loaded + 1'b1;
            if ((16'(words_loaded) + 16'd1) == len_q) begin
              state_nxt = LDR_CSUM;
            end
          end
        end
      end

      LDR_CSUM: begin
        if (fire) begin
          if (in_data == xsum) begin
            state_nxt     = LDR_DONE;
            done_nxt      = 1'b1;
            cpu_reset_nxt = 1'b0;
          end else begin
            state_nxt     = LDR_ERROR;
            error_nxt     = 1'b1;
            cpu_reset_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = LDR_IDLE;
    endcase

    // Registered from the next state so they track the state exactly.
    in_ready_nxt = ldr_accepting(state_nxt);
    busy_nxt     = ldr_accepting(state_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= LDR_IDLE;
      in_ready     <= 1'b0;
      im_we        <= 1'b0;
      im_addr      <= '0;
      im_wdata     <= 32'd0;
      words_loaded <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_reset    <= 1'b1;
      word_idx     <= '0;
      len_hi       <= 8'd0;
      len_q        <= 16'd0;
      xsum         <= 8'd0;
    end else begin
      state        <= state_nxt;
      in_ready     <= in_ready_nxt;
      im_we        <= im_we_nxt;
      im_addr      <= im_addr_nxt;
      im_wdata     <= im_wdata_nxt;
      words_loaded <= words_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
      cpu_reset    <= cpu_reset_nxt;
      word_idx     <= word_idx_nxt;
      len_hi       <= len_hi_nxt;
      len_q        <= len_nxt;
      xsum         <= xsum_nxt;
    end
  end

endmodule
